// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package tlb_pkg;

  localparam int PAGE_OFFSET_WIDTH = 12;
  localparam int PAGE_NUMBER_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WALK   = 2'd2
  } state_t;

  typedef struct packed {
    logic                         valid;
    logic [PAGE_NUMBER_WIDTH-1:0] tag;
    logic [PAGE_NUMBER_WIDTH-1:0] frame;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_victim_select.sv
// Picks the entry to overwrite on a fill: lowest free slot, else the round-robin pointer.
// Latency: purely combinational.
// Backpressure: none.
module tlb_victim_select #(
  parameter int ENTRIES   = 8,
  parameter int PTR_WIDTH = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]   valid,
  input  logic [PTR_WIDTH-1:0] pointer,
  output logic [PTR_WIDTH-1:0] victim,
  output logic                 uses_pointer
);

  // Scan from the top down so the lowest invalid index is the last one written.
  always_comb begin
    uses_pointer = &valid;
    victim       = pointer;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) victim = PTR_WIDTH'(i);
    end
  end

endmodule

// File: rtl/tlb_controller.sv
// Fully associative TLB in front of the page walker; hits answer locally, misses issue one walk and fill.
// Latency: hit -> o_ready registered one cycle after LOOKUP; miss -> o_ready the cycle after i_walk_ready.
// Backpressure: none; i_vaild while busy is ignored, requester holds it until o_ready.
module tlb_controller
  import tlb_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int PTR_WIDTH = $clog2(ENTRIES)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_vaild,
  output logic        o_ready,
  input  logic [31:0] i_linear_address,
  output logic [31:0] o_physical_address,
  output logic        o_hit,
  output logic        o_busy,
  input  logic        i_flush,
  output logic        o_walk_vaild,
  input  logic        i_walk_ready,
  output logic [31:0] o_walk_linear_address,
  input  logic [31:0] i_walk_physical_address
);

  state_t               state, state_next;
  tlb_entry_t           entries [ENTRIES];
  logic [ENTRIES-1:0]   valid_vec;
  logic [PTR_WIDTH-1:0] pointer;
  logic [PTR_WIDTH-1:0] victim;
  logic                 uses_pointer;
  logic [31:0]          req_addr;
  logic                 flush_pending;
  logic                 hit_found;
  logic [PTR_WIDTH-1:0] hit_idx;
  logic                 ready_set, hit_set, walk_start, do_fill;

  assign o_busy = (state != IDLE);

  // Collect valid bits and find the matching entry; lowest index wins on a (theoretical) double match.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    valid_vec = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      valid_vec[i] = entries[i].valid;
      if (entries[i].valid &&
          entries[i].tag == req_addr[31:PAGE_OFFSET_WIDTH]) begin
        hit_found = 1'b1;
        hit_idx   = PTR_WIDTH'(i);
      end
    end
  end

  tlb_victim_select #(
    .ENTRIES  (ENTRIES),
    .PTR_WIDTH(PTR_WIDTH)
  ) u_victim (
    .valid       (valid_vec),
    .pointer     (pointer),
    .victim      (victim),
    .uses_pointer(uses_pointer)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and per-cycle strobes; a flush during LOOKUP forces the miss path.
  always_comb begin
    state_next = state;
    ready_set  = 1'b0;
    hit_set    = 1'b0;
    walk_start = 1'b0;
    do_fill    = 1'b0;
    case (state)
      IDLE: begin
        if (i_vaild) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit_found && !i_flush) begin
          ready_set  = 1'b1;
          hit_set    = 1'b1;
          state_next = IDLE;
        end else begin
          walk_start = 1'b1;
          state_next = WALK;
        end
      end
      WALK: begin
        if (i_walk_ready) begin
          ready_set  = 1'b1;
          do_fill    = !flush_pending && !i_flush;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request latch, registered outputs, entry array and replacement pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr              <= '0;
      o_ready               <= 1'b0;
      o_hit                 <= 1'b0;
      o_physical_address    <= '0;
      o_walk_vaild          <= 1'b0;
      o_walk_linear_address <= '0;
      flush_pending         <= 1'b0;
      pointer               <= '0;
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
    end else begin
      o_ready      <= ready_set;
      o_walk_vaild <= walk_start;
      if (state == IDLE && i_vaild) req_addr <= i_linear_address;
      if (walk_start) o_walk_linear_address <= req_addr;
      if (ready_set) begin
        o_hit <= hit_set;
        o_physical_address <= hit_set
          ? {entries[hit_idx].frame, req_addr[PAGE_OFFSET_WIDTH-1:0]}
          : i_walk_physical_address;
      end

      if (state_next == IDLE)          flush_pending <= 1'b0;
      else if (state == WALK && i_flush) flush_pending <= 1'b1;

      if (i_flush) begin
        pointer <= '0;
        for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
      end else if (do_fill) begin
        entries[victim].valid <= 1'b1;
        entries[victim].tag   <= req_addr[31:PAGE_OFFSET_WIDTH];
        entries[victim].frame <= i_walk_physical_address[31:PAGE_OFFSET_WIDTH];
        if (uses_pointer) pointer <= pointer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tlb_controller.sv
// Randomized bench for tlb_controller against a slot-level reference TLB.
// Latency: n/a.
// Backpressure: n/a.
module tb_tlb_controller;

  localparam int ENTRIES = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_vaild;
  logic        o_ready;
  logic [31:0] i_linear_address;
  logic [31:0] o_physical_address;
  logic        o_hit;
  logic        o_busy;
  logic        i_flush;
  logic        o_walk_vaild;
  logic        i_walk_ready;
  logic [31:0] o_walk_linear_address;
  logic [31:0] i_walk_physical_address;

  int checks   = 0;
  int failures = 0;

  // Reference TLB: slots with valid/page/frame, plus the round-robin pointer.
  bit          m_valid [ENTRIES];
  logic [19:0] m_page  [ENTRIES];
  logic [19:0] m_frame [ENTRIES];
  int          m_ptr;

  tlb_controller #(.ENTRIES(ENTRIES)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .i_vaild                (i_vaild),
    .o_ready                (o_ready),
    .i_linear_address       (i_linear_address),
    .o_physical_address     (o_physical_address),
    .o_hit                  (o_hit),
    .o_busy                 (o_busy),
    .i_flush                (i_flush),
    .o_walk_vaild           (o_walk_vaild),
    .i_walk_ready           (i_walk_ready),
    .o_walk_linear_address  (o_walk_linear_address),
    .i_walk_physical_address(i_walk_physical_address)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    m_ptr = 0;
  endfunction

  function automatic int model_find(input logic [19:0] page);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_page[i] == page) return i;
    return -1;
  endfunction

  function automatic void model_fill(input logic [19:0] page, input logic [19:0] frame);
    int slot = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i] && slot < 0) slot = i;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % ENTRIES;
    end
    m_valid[slot] = 1;
    m_page[slot]  = page;
    m_frame[slot] = frame;
  endfunction

  task automatic do_flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    model_clear();
    check("idle_flush_busy", {31'd0, o_busy}, 32'd0);
  endtask

  // One request. flush_lookup pulses i_flush while in LOOKUP; flush_at (0..wait_n) pulses it in WALK.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wphys,
                        input bit flush_lookup, input int flush_at, input int wait_n,
                        output logic got_hit);
    int  slot;
    bit  flushed = 0;
    logic [31:0] exp_pa;
    slot = model_find(addr[31:12]);
    if (flush_lookup) begin
      model_clear();
      slot = -1;
    end
    i_vaild          = 1'b1;
    i_linear_address = addr;
    tick();
    i_vaild = 1'b0;
    i_flush = flush_lookup;
    check("accept_busy", {31'd0, o_busy}, 32'd1);
    tick();
    i_flush = 1'b0;
    got_hit = 1'b0;
    if (slot >= 0) begin
      exp_pa = {m_frame[slot], addr[11:0]};
      check("hit_ready", {31'd0, o_ready}, 32'd1);
      check("hit_flag", {31'd0, o_hit}, 32'd1);
      check("hit_pa", o_physical_address, exp_pa);
      check("hit_no_walk", {31'd0, o_walk_vaild}, 32'd0);
      check("hit_busy", {31'd0, o_busy}, 32'd0);
      got_hit = o_hit;
    end else begin
      check("miss_walk_vld", {31'd0, o_walk_vaild}, 32'd1);
      check("miss_walk_addr", o_walk_linear_address, addr);
      check("miss_no_ready", {31'd0, o_ready}, 32'd0);
      for (int k = 0; k < wait_n; k++) begin
        if (flush_at == k) begin
          i_flush = 1'b1;
          flushed = 1;
          model_clear();
        end
        tick();
        i_flush = 1'b0;
        check("walk_vld_low", {31'd0, o_walk_vaild}, 32'd0);
        check("walk_no_ready", {31'd0, o_ready}, 32'd0);
        check("walk_addr_stable", o_walk_linear_address, addr);
      end
      if (flush_at == wait_n) begin
        i_flush = 1'b1;
        flushed = 1;
        model_clear();
      end
      i_walk_ready            = 1'b1;
      i_walk_physical_address = wphys;
      tick();
      i_walk_ready = 1'b0;
      i_flush      = 1'b0;
      i_walk_physical_address = $urandom;
      check("walk_ready", {31'd0, o_ready}, 32'd1);
      check("walk_hit_flag", {31'd0, o_hit}, 32'd0);
      check("walk_pa", o_physical_address, wphys);
      check("walk_idle", {31'd0, o_busy}, 32'd0);
      if (!flushed) model_fill(addr[31:12], wphys[31:12]);
      got_hit = o_hit;
    end
    tick();
    check("ready_pulse_low", {31'd0, o_ready}, 32'd0);
  endtask

  initial begin
    logic        h;
    logic [31:0] a;
    int          r, p, w, fa;

    reset = 1'b1; i_vaild = 1'b0; i_linear_address = '0; i_flush = 1'b0;
    i_walk_ready = 1'b0; i_walk_physical_address = '0;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_hit", {31'd0, o_hit}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_walk_vld", {31'd0, o_walk_vaild}, 32'd0);
    check("rst_pa", o_physical_address, 32'd0);
    check("rst_walk_addr", o_walk_linear_address, 32'd0);

    // First miss then hit on the same page.
    do_req(32'h0040_1234, 32'h0012_3234, 0, -1, 2, h);
    check("tp_first_miss", {31'd0, h}, 32'd0);
    do_req(32'h0040_1ABC, 32'h0, 0, -1, 0, h);
    check("tp_second_hit", {31'd0, h}, 32'd1);
    check("tp_second_pa", o_physical_address, 32'h0012_3ABC);

    // Fill nine distinct pages into an empty buffer; the ninth evicts entry 0.
    do_flush();
    for (int pg = 0; pg < 9; pg++)
      do_req({pg[19:0], 12'h010}, {12'h100, pg[19:0]} << 12, 0, -1, 1, h);
    do_req(32'h0000_1044, 32'h0, 0, -1, 0, h);
    check("tp_page1_hit", {31'd0, h}, 32'd1);
    do_req(32'h0000_0044, 32'h0777_7044, 0, -1, 0, h);
    check("tp_page0_miss", {31'd0, h}, 32'd0);

    // Idle flush forgets a cached page.
    do_flush();
    do_req(32'h0000_3000, 32'h0333_3000, 0, -1, 0, h);
    check("tp_after_flush_miss", {31'd0, h}, 32'd0);

    // Flush during a walk: result returned, not cached.
    do_req(32'h0055_5010, 32'h0AB0_0010, 0, 1, 3, h);
    check("tp_walk_flush_pa", o_physical_address, 32'h0AB0_0010);
    do_req(32'h0055_5010, 32'h0AB0_0010, 0, -1, 0, h);
    check("tp_walk_flush_remiss", {31'd0, h}, 32'd0);

    // Reset while walking, then a stray walk-ready.
    i_vaild = 1'b1; i_linear_address = 32'h0000_2000;
    tick();
    i_vaild = 1'b0;
    tick();
    check("rw_walk_vld", {31'd0, o_walk_vaild}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check("rw_busy", {31'd0, o_busy}, 32'd0);
    check("rw_walk_vld_low", {31'd0, o_walk_vaild}, 32'd0);
    check("rw_ready", {31'd0, o_ready}, 32'd0);
    i_walk_ready = 1'b1; i_walk_physical_address = 32'h0BAD_0000;
    tick();
    i_walk_ready = 1'b0;
    check("rw_late_ready", {31'd0, o_ready}, 32'd0);
    check("rw_late_busy", {31'd0, o_busy}, 32'd0);
    do_req(32'h0055_5010, 32'h0123_4010, 0, -1, 0, h);
    check("rw_remiss", {31'd0, h}, 32'd0);

    // Randomized traffic over a small page pool to exercise eviction and flushes.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      p = $urandom_range(0, 11);
      w = $urandom_range(0, 3);
      a = {p[19:0], 12'($urandom)};
      fa = (r >= 10 && r < 20) ? $urandom_range(0, w) : -1;
      if (r < 5) do_flush();
      do_req(a, $urandom, (r >= 5 && r < 10), fa, w, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
